// File: rtl/mem_copy_engine.sv
// Block-copy master for the data memory: reads one word, writes it back, and repeats,
// taking two cycles per word in ascending address order.
module mem_copy_engine #(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned LEN_BITS  = 11
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic [31:0]         SrcAddr,
    input  logic [31:0]         DstAddr,
    input  logic [LEN_BITS-1:0] Length,
    input  logic [31:0]         ReadData,
    output logic [31:0]         Endereco,
    output logic [31:0]         DadosEscrita,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                Busy,
    output logic                Done,
    output logic [LEN_BITS-1:0] Count
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t                 state;
    logic [ADDR_BITS-1:0]   src;
    logic [ADDR_BITS-1:0]   dst;
    logic [LEN_BITS-1:0]    len;
    logic [LEN_BITS-1:0]    count;
    logic [ADDR_BITS-1:0]   addr;
    logic [31:0]            wdata;
    logic                   rd;
    logic                   wr;
    logic                   busy;
    logic                   done;

    logic [LEN_BITS-1:0]    len_clamped;
    logic [LEN_BITS-1:0]    count_inc;
    logic                   unused_addr_bits;

    // Requests longer than the memory are trimmed to one full pass.
    assign len_clamped = (Length > MAX_LEN) ? MAX_LEN : Length;
    assign count_inc   = count + LEN_BITS'(1);

    // Upper address bits are outside the memory and intentionally ignored.
    assign unused_addr_bits = ^{SrcAddr[31:ADDR_BITS], DstAddr[31:ADDR_BITS]};

    // Copy sequencer; outputs are loaded together with the state they belong to.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            src   <= '0;
            dst   <= '0;
            len   <= '0;
            count <= '0;
            addr  <= '0;
            wdata <= '0;
            rd    <= 1'b0;
            wr    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rd   <= 1'b0;
                    wr   <= 1'b0;
                    done <= 1'b0;
                    if (Start) begin
                        src   <= SrcAddr[ADDR_BITS-1:0];
                        dst   <= DstAddr[ADDR_BITS-1:0];
                        len   <= len_clamped;
                        count <= '0;
                        busy  <= 1'b1;
                        if (len_clamped != '0) begin
                            state <= READ;
                            addr  <= SrcAddr[ADDR_BITS-1:0];
                            rd    <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                READ: begin
                    wdata <= ReadData;
                    addr  <= dst + ADDR_BITS'(count);
                    rd    <= 1'b0;
                    wr    <= 1'b1;
                    state <= WRITE;
                end
                WRITE: begin
                    count <= count_inc;
                    wr    <= 1'b0;
                    if (count_inc == len) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= READ;
                        addr  <= src + ADDR_BITS'(count_inc);
                        rd    <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Endereco     = 32'(addr);
    assign DadosEscrita = wdata;
    assign MemRead      = rd;
    assign MemWrite     = wr;
    assign Busy         = busy;
    assign Done         = done;
    assign Count        = count;

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
Initiator-side master for the data memory: copies a block of words from a source word address to a destination word address. It drives the memory's address, write data, MemRead and MemWrite, and consumes its combinational read data. The data memory reads asynchronously and writes on the falling edge of Clock. This engine runs on the rising edge, so the write data and strobe it launches are stable at that falling edge.

Parameters:
ADDR_BITS, 10, word-address bits actually used by the data memory (DEPTH = 2**ADDR_BITS = 1024 words).
LEN_BITS, 11, width of Length (allows 0..1024 words).

Ports:
Clock  input  1  system clock; all state updates on posedge.
Reset  input  1  asynchronous, active-low reset.
Start  input  1  request a copy; sampled on posedge only while idle.
SrcAddr  input  32  source word address; only low ADDR_BITS used.
DstAddr  input  32  destination word address; only low ADDR_BITS used.
Length  input  LEN_BITS  number of words to copy.
ReadData  input  32  combinational read data from data memory.
Endereco  output  32  word address to data memory.
DadosEscrita  output  32  write data to data memory.
MemRead  output  1  read strobe.
MemWrite  output  1  write strobe.
Busy  output  1  high in any state other than IDLE.
Done  output  1  one-cycle completion pulse.
Count  output  LEN_BITS  words written so far in the current or last copy.

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE; Endereco=0, DadosEscrita=0, MemRead=0, MemWrite=0, Busy=0, Done=0, Count=0. Internal src/dst/len registers are cleared. A reset asserted mid-copy aborts the copy immediately; no further writes occur and there is no Done.
- States: IDLE, READ, WRITE, DONE. All outputs are registered or decoded from state plus registers, so they are glitch-free within the cycle.
- IDLE: strobes are 0 and Endereco holds its last value.
  - Start=1 at a posedge: latch SrcAddr, DstAddr, Length and clear Count.
  - Next state is READ if Length!=0, else DONE.
- READ, one cycle: Endereco = {0, (src+Count) mod DEPTH}, MemRead=1, MemWrite=0. At the ending posedge, ReadData is captured into DadosEscrita. Next state is WRITE.
- WRITE, one cycle: Endereco = {0, (dst+Count) mod DEPTH}, MemWrite=1, MemRead=0, DadosEscrita held. The memory commits the word at this cycle's falling edge. At the ending posedge Count increments; next state is DONE if Count+1==len, else READ.
- DONE, one cycle: Done=1, strobes 0, Busy=1. Next state is IDLE.
- Timing: 2 cycles per word. With Start sampled at posedge k, Done is high during cycle k+2N+1 and Busy falls after it. Length=0 gives Done in cycle k+1 with zero memory accesses.
- Address arithmetic is modulo DEPTH: a source or destination running past DEPTH-1 wraps to 0. Endereco[31:ADDR_BITS] is always 0.
- Length values above DEPTH are clamped to DEPTH.
- Copy order is ascending only. With overlapping regions where dst>src, already-overwritten words propagate; this is the defined behaviour.
- Start while Busy is ignored, and input changes while Busy have no effect.
- Start held high continuously: a new copy begins on the first posedge in IDLE after DONE, i.e. one idle cycle between copies.
- MemRead and MemWrite are never high in the same cycle.

Test Plan:
- Reset, then preload mem[10..13]={A,B,C,D}; Start with Src=10, Dst=100, Len=4 → mem[100..103]={A,B,C,D}, Done high exactly at cycle k+9, Count=4, MemWrite asserted 4 times.
- Len=0, Src=5, Dst=6 → no MemRead/MemWrite, Done at k+1, memory unchanged.
- Wrap: Src=1022, Dst=0, Len=4 with mem[1022]=E, mem[1023]=F, mem[0]=G, mem[1]=H → reads addresses 1022,1023,0,1 and writes 0,1,2,3; result mem[0..3]={E,F,E,F} (overlap rule).
- Reset asserted during the third WRITE of a Len=8 copy → exactly 2 words written (third suppressed if reset precedes negedge), all outputs 0 asynchronously, no Done, Busy=0; a fresh Start then works normally.
- Start pulsed again while Busy with different Src/Dst → ignored; first copy completes unchanged and only one Done is seen.
- Start held high with Len=1 → Done pulses every 4 cycles (READ, WRITE, DONE, IDLE), and MemRead/MemWrite are never simultaneously 1.
